uart_rx_depacketizer: RTL and testbench



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_core.sv | 94 +++++++++
 rtl/uart_rx_depacketizer.sv | 90 +++++++++
 tb/tb_uart_rx_depacketizer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Constants and receiver state encoding shared by the UART transmitter and receiver.
package uart_pkg;

    localparam int unsigned BAUD_DIV_DEF   = 16;
    localparam int unsigned DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver core: 2-flop line synchronizer, bit-timing FSM and shift register.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_byte,
    output logic                  byte_strobe,
    output logic                  stop_ok,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned IDX_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic                  rx_m;
    logic                  rx_s;
    logic [CNT_W-1:0]      cnt;
    logic [IDX_W-1:0]      bit_idx;
    logic [DATA_WIDTH-1:0] shreg;

    assign busy = (state != IDLE);

    // Synchronizer resets high so a released reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            rx_byte     <= '0;
            byte_strobe <= 1'b0;
            stop_ok     <= 1'b0;
        end else begin
            rx_m        <= rx_in;
            rx_s        <= rx_m;
            byte_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt         <= '0;
                        byte_strobe <= 1'b1;
                        stop_ok     <= rx_s;
                        rx_byte     <= shreg;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_depacketizer.sv
// UART receive path: rx core feeding a receive FIFO, with framing and overrun pulses.
module uart_rx_depacketizer
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = BAUD_DIV_DEF,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  rx_busy,
    output logic                  frame_err,
    output logic                  overrun
);

    typedef logic [ADDR_WIDTH:0] count_t;

    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  byte_strobe;
    logic                  stop_ok;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    count_t                count;
    logic                  good;
    logic                  push;
    logic                  pop;

    uart_rx_core #(
        .BAUD_DIV   (BAUD_DIV),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe),
        .stop_ok     (stop_ok),
        .busy        (rx_busy)
    );

    assign fifo_full  = (count == count_t'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign pop        = rd_en && !fifo_empty;
    assign good       = byte_strobe && stop_ok;
    // A simultaneous pop frees a slot, so a full FIFO still accepts the byte.
    assign push       = good && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            data_valid <= pop;
            frame_err  <= byte_strobe && !stop_ok;
            overrun    <= good && !push;
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + count_t'(1);
                2'b01:   count <= count - count_t'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_depacketizer.sv
// Directed self-checking bench for uart_rx_depacketizer (BAUD_DIV=16, 8N1, 16-deep FIFO).
module tb_uart_rx_depacketizer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       rx_in = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       fifo_full;
    logic       fifo_empty;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun;

    int unsigned cyc        = 0;
    int unsigned checks     = 0;
    int unsigned passes     = 0;
    int unsigned ferr_cnt   = 0;
    int unsigned ovr_cnt    = 0;
    int unsigned valid_cnt  = 0;
    int unsigned fall_cyc   = 0;
    int unsigned start_cyc  = 0;
    int unsigned ovr0;
    int unsigned v0;
    logic [7:0]  last_pop   = 8'h00;
    logic        empty_q    = 1'b1;

    uart_rx_depacketizer #(
        .BAUD_DIV   (16),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16),
        .ADDR_WIDTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .rd_en      (rd_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Pulse and edge monitor, sampled on the inactive edge.
    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (overrun) ovr_cnt++;
        if (data_valid) begin
            valid_cnt++;
            last_pop = data_out;
        end
        if (empty_q && !fifo_empty) fall_cyc = cyc;
        empty_q = fifo_empty;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Drives one frame for n_cyc cycles; rd_en is raised for the single cycle j == pop_j.
    task automatic drive_frame(input logic [7:0] d, input logic stop, input int pop_j, input int n_cyc);
        int unsigned b;
        start_cyc = cyc;
        for (int j = 0; j < n_cyc; j++) begin
            b = j / 16;
            if (b == 0) rx_in = 1'b0;
            else if (b == 9) rx_in = stop;
            else rx_in = d[b-1];
            rd_en = (j == pop_j);
            tick();
        end
        rd_en = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic stop);
        drive_frame(d, stop, -1, 160);
        rx_in = 1'b1;
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, {31'd0, data_valid}, 32'd1);
        check(tag, {24'd0, data_out}, {24'd0, exp});
    endtask

    initial begin
        repeat (3) tick();
        check("rst_data_out", {24'd0, data_out}, 32'h00);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_full", {31'd0, fifo_full}, 32'd0);
        check("rst_empty", {31'd0, fifo_empty}, 32'd1);
        check("rst_busy", {31'd0, rx_busy}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        repeat (5) tick();

        // Single good byte and its latency
        send(8'hA5, 1'b1);
        check("t1_latency", fall_cyc - start_cyc, 32'd156);
        check("t1_not_empty", {31'd0, fifo_empty}, 32'd0);
        check("t1_ferr", ferr_cnt, 32'd0);
        pop_check("t1_pop", 8'hA5);
        check("t1_empty_after", {31'd0, fifo_empty}, 32'd1);
        tick();
        check("t1_valid_1cyc", {31'd0, data_valid}, 32'd0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check("rd_empty_valid", {31'd0, data_valid}, 32'd0);
        check("rd_empty_hold", {24'd0, data_out}, 32'hA5);

        // Framing error followed by a good byte
        send(8'h3C, 1'b0);
        repeat (24) tick();
        check("t3_ferr", ferr_cnt, 32'd1);
        check("t3_empty", {31'd0, fifo_empty}, 32'd1);
        send(8'h5A, 1'b1);
        check("t3_good_pushed", {31'd0, fifo_empty}, 32'd0);
        check("t3_ferr_once", ferr_cnt, 32'd1);

        // Short glitch on an idle line
        rx_in = 1'b0;
        repeat (4) tick();
        rx_in = 1'b1;
        check("t4_busy", {31'd0, rx_busy}, 32'd1);
        repeat (20) tick();
        check("t4_idle", {31'd0, rx_busy}, 32'd0);
        check("t4_ferr", ferr_cnt, 32'd1);
        pop_check("t3_pop", 8'h5A);
        check("t4_no_push", {31'd0, fifo_empty}, 32'd1);

        // Reset in the middle of a frame with a byte queued
        send(8'h42, 1'b1);
        check("t5_queued", {31'd0, fifo_empty}, 32'd0);
        drive_frame(8'h99, 1'b1, -1, 72);
        check("t5_busy_pre", {31'd0, rx_busy}, 32'd1);
        rst = 1'b0;
        #1;
        check("t5_rst_data_out", {24'd0, data_out}, 32'h00);
        check("t5_rst_empty", {31'd0, fifo_empty}, 32'd1);
        check("t5_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("t5_rst_full", {31'd0, fifo_full}, 32'd0);
        rx_in = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (5) tick();
        send(8'h7E, 1'b1);
        pop_check("t5_pop", 8'h7E);
        check("t5_only_one", {31'd0, fifo_empty}, 32'd1);

        // Fill to full, overrun, push+pop while full, then drain across wrap
        ovr0 = ovr_cnt;
        for (int i = 1; i <= 16; i++) begin
            send(i[7:0], 1'b1);
        end
        check("t2_full", {31'd0, fifo_full}, 32'd1);
        check("t2_no_ovr", ovr_cnt - ovr0, 32'd0);
        send(8'h11, 1'b1);
        check("t2_ovr_once", ovr_cnt - ovr0, 32'd1);
        check("t2_still_full", {31'd0, fifo_full}, 32'd1);
        v0 = valid_cnt;
        drive_frame(8'h12, 1'b1, 155, 160);
        rx_in = 1'b1;
        check("t6_one_pop", valid_cnt - v0, 32'd1);
        check("t6_pop_head", {24'd0, last_pop}, 32'h01);
        check("t6_full", {31'd0, fifo_full}, 32'd1);
        check("t6_no_ovr", ovr_cnt - ovr0, 32'd1);
        for (int i = 2; i <= 16; i++) begin
            pop_check("t2_drain", i[7:0]);
        end
        pop_check("t6_drain_last", 8'h12);
        check("t2_empty", {31'd0, fifo_empty}, 32'd1);
        check("t2_ferr", ferr_cnt, 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
